// File: rtl/ipv4_rx_if.sv
// Word stream between receive stages: valid word, byte count and an
// abort strobe. No backpressure, so there is no ready.
interface ipv4_rx_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 2
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
    logic              cancel;

    modport master (output valid, data, len, cancel);
    modport slave  (input  valid, data, len, cancel);
endinterface

// File: rtl/ipv4_rx.sv
// IPv4 receive stage: header parse/filter, checksum check and
// forwarding of the payload trimmed to the IP total length.
module ipv4_rx #(
    parameter int          DATA_W  = 16,
    parameter int          LEN_W   = 2,
    parameter logic [31:0] IP_ADDR = 32'hC0A8_0102
) (
    input  logic      clk,
    input  logic      nreset,
    ipv4_rx_if.slave  rx,
    ipv4_rx_if.master tx,
    output logic      ip_cs_err_o
);
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        HEAD = 4'b0010,
        DATA = 4'b0100,
        DROP = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [15:0]       tl_q, tl_d;
    logic [15:0]       bcnt_q, bcnt_d;
    logic [16:0]       csum_q, csum_d;
    logic              bad_q, bad_d;
    logic              fwd_q, fwd_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic              cxl_q, cxl_d;

    logic [16:0]       acc;
    logic [15:0]       fold;
    logic [15:0]       rem;
    logic [15:0]       len_ext;
    logic              last;
    logic              hbad;

    always_comb begin
        acc     = {1'b0, csum_q[15:0]} + {16'd0, csum_q[16]}
                + {1'b0, rx.data};
        fold    = acc[15:0] + {15'd0, acc[16]};
        rem     = tl_q - bcnt_q;
        len_ext = {{(16 - LEN_W){1'b0}}, rx.len};
        last    = len_ext >= rem;

        // Per-word header requirements; DF (bit 14 of w3) is ignored.
        case (wcnt_q)
            4'd3:    hbad = rx.data[13:0] != 14'd0;
            4'd4:    hbad = rx.data[7:0] != 8'd17;
            4'd8:    hbad = rx.data != IP_ADDR[31:16];
            4'd9:    hbad = rx.data != IP_ADDR[15:0];
            default: hbad = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tl_d    = tl_q;
        bcnt_d  = bcnt_q;
        csum_d  = csum_q;
        bad_d   = bad_q;
        fwd_d   = fwd_q;
        valid_d = 1'b0;
        data_d  = data_q;
        len_d   = len_q;
        err_d   = err_q;
        cxl_d   = 1'b0;

        if (rx.cancel) begin
            state_d = IDLE;
            cxl_d   = state_q == DATA;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx.valid) begin
                        state_d = (rx.len == LEN_W'(2)) ? HEAD : IDLE;
                        wcnt_d  = 4'd1;
                        csum_d  = {1'b0, rx.data};
                        bad_d   = rx.data[15:8] != 8'h45;
                        fwd_d   = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                HEAD: begin
                    if (!rx.valid || rx.len != LEN_W'(2)) begin
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                        csum_d = acc;
                        bad_d  = bad_q | hbad;
                        if (wcnt_q == 4'd1) tl_d = rx.data;
                        if (wcnt_q == 4'd9) begin
                            err_d  = fold != 16'hFFFF;
                            bcnt_d = 16'd20;
                            if (bad_q || hbad || tl_q < 16'd20)
                                state_d = DROP;
                            else if (tl_q == 16'd20)
                                state_d = IDLE;
                            else
                                state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (!rx.valid) begin
                        state_d = IDLE;
                        cxl_d   = fwd_q;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = rx.data;
                        fwd_d   = 1'b1;
                        // Final word: clip to TL, then swallow padding.
                        if (last) begin
                            len_d   = rem[LEN_W-1:0];
                            bcnt_d  = tl_q;
                            state_d = DROP;
                        end else begin
                            len_d  = rx.len;
                            bcnt_d = bcnt_q + len_ext;
                        end
                    end
                end
                DROP: begin
                    if (!rx.valid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            tl_q    <= '0;
            bcnt_q  <= '0;
            csum_q  <= '0;
            bad_q   <= 1'b0;
            fwd_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            cxl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tl_q    <= tl_d;
            bcnt_q  <= bcnt_d;
            csum_q  <= csum_d;
            bad_q   <= bad_d;
            fwd_q   <= fwd_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            len_q   <= len_d;
            err_q   <= err_d;
            cxl_q   <= cxl_d;
        end
    end

    assign tx.valid    = valid_q;
    assign tx.data     = data_q;
    assign tx.len      = len_q;
    assign tx.cancel   = cxl_q;
    assign ip_cs_err_o = err_q;
endmodule

// File: tb/tb_ipv4_rx.sv
// Directed bench for ipv4_rx: good/trimmed/corrupt/filtered packets,
// aborts, truncation and mid-packet reset.
module tb_ipv4_rx;
    localparam logic [31:0] MY_IP = 32'hC0A8_0102;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic ip_cs_err_o;

    ipv4_rx_if #(.DATA_W(16), .LEN_W(2)) rx ();
    ipv4_rx_if #(.DATA_W(16), .LEN_W(2)) tx ();

    ipv4_rx #(
        .DATA_W (16),
        .LEN_W  (2),
        .IP_ADDR(MY_IP)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .rx         (rx.slave),
        .tx         (tx.master),
        .ip_cs_err_o(ip_cs_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int nw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] od[$];
    logic [1:0]  ol[$];
    logic        oe[$];
    int          oc[$];
    int          cc[$];

    always @(negedge clk) begin
        if (tx.valid) begin
            od.push_back(tx.data);
            ol.push_back(tx.len);
            oe.push_back(ip_cs_err_o);
            oc.push_back(cyc);
        end
        if (tx.cancel) cc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] fw[32];
    logic [1:0]  fl[32];

    function automatic logic [15:0] ones_sum();
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 10; i++) s += {16'd0, fw[i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return s[15:0];
    endfunction

    task automatic mk(input logic [15:0] tl, input logic [7:0] pr,
                      input logic [31:0] dst, input logic mf,
                      input logic cs_bad, input int npw);
        fw[0] = 16'h4500;
        fw[1] = tl;
        fw[2] = 16'h1234;
        fw[3] = mf ? 16'h2000 : 16'h4000;
        fw[4] = {8'h40, pr};
        fw[5] = 16'h0000;
        fw[6] = 16'hC0A8;
        fw[7] = 16'h0101;
        fw[8] = dst[31:16];
        fw[9] = dst[15:0];
        fw[5] = ~ones_sum();
        if (cs_bad) fw[5] = fw[5] ^ 16'h0001;
        for (int i = 0; i < 32; i++) fl[i] = 2'd2;
        for (int i = 0; i < npw; i++) fw[10 + i] = 16'(i + 1);
        nw = 10 + npw;
    endtask

    task automatic run(input int cx);
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            rx.valid  = 1'b1;
            rx.data   = fw[i];
            rx.len    = fl[i];
            rx.cancel = (i == cx);
            if (i == 10) t0 = cyc;
            if (i == cx) break;
        end
        @(negedge clk);
        rx.valid  = 1'b0;
        rx.cancel = 1'b0;
        rx.data   = 16'd0;
        rx.len    = 2'd0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic clr();
        od.delete();
        ol.delete();
        oe.delete();
        oc.delete();
        cc.delete();
    endtask

    task automatic expect_pay(input string tag, input int n,
                              input logic [1:0] lastlen, input logic err);
        chk({tag, "_n"}, od.size(), n);
        for (int k = 0; k < n && k < od.size(); k++) begin
            chk({tag, "_d"}, od[k], fw[10 + k]);
            chk({tag, "_l"}, ol[k], (k == n - 1) ? lastlen : 2'd2);
            chk({tag, "_e"}, oe[k], err);
            chk({tag, "_t"}, oc[k], t0 + 1 + k);
        end
    endtask

    initial begin
        rx.valid  = 1'b0;
        rx.data   = 16'd0;
        rx.len    = 2'd0;
        rx.cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_v", tx.valid, 0);
        chk("rst_d", tx.data, 0);
        chk("rst_l", tx.len, 0);
        chk("rst_e", ip_cs_err_o, 0);
        chk("rst_c", tx.cancel, 0);
        nreset = 1'b1;
        @(negedge clk);

        clr();
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b0, 4);
        run(-1);
        settle();
        expect_pay("good", 4, 2'd2, 1'b0);
        chk("good_cx", cc.size(), 0);

        clr();
        mk(16'd29, 8'd17, MY_IP, 1'b0, 1'b0, 4);
        fw[14] = 16'h05AA;
        for (int i = 15; i < 23; i++) fw[i] = 16'hAAAA;
        nw = 23;
        run(-1);
        settle();
        expect_pay("trim", 5, 2'd1, 1'b0);
        if (od.size() == 5) chk("trim_b", od[4][15:8], 8'h05);

        clr();
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b1, 4);
        run(-1);
        settle();
        expect_pay("csum", 4, 2'd2, 1'b1);

        clr();
        mk(16'd28, 8'd6, MY_IP, 1'b0, 1'b0, 4);
        run(-1);
        mk(16'd28, 8'd17, 32'hC0A8_0103, 1'b0, 1'b0, 4);
        run(-1);
        mk(16'd28, 8'd17, MY_IP, 1'b1, 1'b0, 4);
        run(-1);
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b0, 4);
        run(-1);
        settle();
        expect_pay("filt", 4, 2'd2, 1'b0);

        clr();
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b0, 4);
        run(11);
        settle();
        expect_pay("abort", 1, 2'd2, 1'b0);
        chk("abort_cn", cc.size(), 1);
        if (cc.size() > 0) chk("abort_ct", cc[0], t0 + 2);

        clr();
        run(-1);
        settle();
        expect_pay("post_ab", 4, 2'd2, 1'b0);

        clr();
        run(4);
        settle();
        chk("hcx_n", od.size(), 0);
        chk("hcx_c", cc.size(), 0);

        clr();
        nw = 12;
        run(-1);
        settle();
        expect_pay("trunc", 2, 2'd2, 1'b0);
        chk("trunc_cn", cc.size(), 1);
        if (cc.size() > 0) chk("trunc_ct", cc[0], t0 + 3);

        clr();
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b1, 4);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rx.valid = 1'b1;
            rx.data  = fw[i];
            rx.len   = fl[i];
            if (i == 12) nreset = 1'b0;
        end
        chk("pre_rst_e", ip_cs_err_o, 1);
        @(negedge clk);
        chk("mid_rst_v", tx.valid, 0);
        chk("mid_rst_d", tx.data, 0);
        chk("mid_rst_l", tx.len, 0);
        chk("mid_rst_e", ip_cs_err_o, 0);
        chk("mid_rst_c", tx.cancel, 0);
        nreset   = 1'b1;
        rx.valid = 1'b0;
        rx.data  = 16'd0;
        rx.len   = 2'd0;
        @(negedge clk);
        chk("mid_rst_cn", cc.size(), 0);

        clr();
        mk(16'd28, 8'd17, MY_IP, 1'b0, 1'b0, 4);
        run(-1);
        settle();
        expect_pay("post_rst", 4, 2'd2, 1'b0);
        chk("post_rst_cn", cc.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
